// File: rtl/sdram_bridge_pkg.sv
// Shared types and defaults for the Wishbone-to-SDRAM controller bridge.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    INIT,
    WAIT_RDY,
    IDLE,
    REQ,
    ACCEPT,
    BUSY,
    DONE
  } state_e;

  localparam logic [2:0] ADDR_PAD       = 3'b000;
  localparam int         INIT_HOLD_DEF  = 4;
  localparam int         ACCEPT_TMO_DEF = 8;
  localparam int         CNT_W          = 4;

endpackage

// File: rtl/sdram_wb_bridge.sv
// Wishbone slave in front of the sdram controller pulse/ready handshake,
// with post-reset init sequencing and a sticky ready flag.
module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int INIT_HOLD  = INIT_HOLD_DEF,
  parameter int ACCEPT_TMO = ACCEPT_TMO_DEF
) (
  input  logic        clk_p,
  input  logic        reset,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [20:0] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  output logic        sdram_ready,
  output logic        ctl_init,
  output logic        ctl_rd,
  output logic        ctl_we,
  output logic [1:0]  ctl_wtbt,
  output logic [24:0] ctl_addr,
  output logic [15:0] ctl_din,
  input  logic [15:0] ctl_dout,
  input  logic        ctl_ready
);

  localparam logic [CNT_W-1:0] INIT_LAST =
    CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(ACCEPT_TMO - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              rdy_q, rdy_d;
  logic              ack_q, ack_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              is_we_q, is_we_d;
  logic              abort_q, abort_d;
  logic [1:0]        wtbt_q, wtbt_d;
  logic [24:0]       addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       dout_q, dout_d;
  logic              fin;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    rdy_d   = rdy_q;
    ack_d   = ack_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    is_we_d = is_we_q;
    abort_d = abort_q;
    wtbt_d  = wtbt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    fin     = 1'b0;

    unique case (state_q)
      INIT: begin
        if (cnt_q == INIT_LAST) begin
          init_d  = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (ctl_ready) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        abort_d = 1'b0;
        if (wb_stb && ctl_ready) begin
          addr_d  = {ADDR_PAD, wb_adr, 1'b0};
          wtbt_d  = wb_we ? wb_sel : 2'b11;
          din_d   = wb_dat_i;
          is_we_d = wb_we;
          state_d = REQ;
        end
      end
      REQ: begin
        rd_d    = !is_we_q;
        wr_d    = is_we_q;
        cnt_d   = '0;
        abort_d = abort_q || !wb_stb;
        state_d = ACCEPT;
      end
      ACCEPT: begin
        abort_d = abort_q || !wb_stb;
        if (!ctl_ready) begin
          state_d = BUSY;
        end else if (cnt_q == TMO_LAST) begin
          // controller never signalled busy: treat as done
          fin = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        abort_d = abort_q || !wb_stb;
        fin     = ctl_ready;
      end
      DONE: begin
        if (!wb_stb) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase

    if (fin) begin
      if (abort_q || !wb_stb) begin
        state_d = IDLE;
      end else begin
        ack_d   = 1'b1;
        state_d = DONE;
        if (!is_we_q) dout_d = ctl_dout;
      end
    end
  end

  always_ff @(posedge clk_p or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      init_q  <= 1'b1;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      is_we_q <= 1'b0;
      abort_q <= 1'b0;
      wtbt_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      is_we_q <= is_we_d;
      abort_q <= abort_d;
      wtbt_q  <= wtbt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  assign wb_dat_o    = dout_q;
  assign wb_ack      = ack_q;
  assign sdram_ready = rdy_q;
  assign ctl_init    = init_q;
  assign ctl_rd      = rd_q;
  assign ctl_we      = wr_q;
  assign ctl_wtbt    = wtbt_q;
  assign ctl_addr    = addr_q;
  assign ctl_din     = din_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Bench for sdram_wb_bridge: behavioural controller plus reference memory,
// directed and random Wishbone transactions.
module tb_sdram_wb_bridge;

  localparam int HOLD_TB = 4;
  localparam int TMO_TB  = 8;

  logic        clk_p = 1'b0;
  logic        reset;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [20:0] wb_adr;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack;
  logic        sdram_ready;
  logic        ctl_init;
  logic        ctl_rd;
  logic        ctl_we;
  logic [1:0]  ctl_wtbt;
  logic [24:0] ctl_addr;
  logic [15:0] ctl_din;
  logic [15:0] ctl_dout;
  logic        ctl_ready;

  sdram_wb_bridge #(
    .INIT_HOLD (HOLD_TB),
    .ACCEPT_TMO(TMO_TB)
  ) dut (
    .clk_p      (clk_p),
    .reset      (reset),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_adr     (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack     (wb_ack),
    .sdram_ready(sdram_ready),
    .ctl_init   (ctl_init),
    .ctl_rd     (ctl_rd),
    .ctl_we     (ctl_we),
    .ctl_wtbt   (ctl_wtbt),
    .ctl_addr   (ctl_addr),
    .ctl_din    (ctl_din),
    .ctl_dout   (ctl_dout),
    .ctl_ready  (ctl_ready)
  );

  always #5 clk_p = ~clk_p;

  int cyc = 0;
  always @(posedge clk_p) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural controller state
  int          busy_n     = 3;
  bit          never_drop = 0;
  int          busy_left;
  bit          start;
  bit          prev_p;
  bit          cur_p;
  int          n_pulse    = 0;
  int          last_pulse = 0;
  int          proto_err  = 0;
  logic [24:0] cap_addr;
  logic [1:0]  cap_wtbt;
  logic [15:0] cap_din;
  logic        cap_we;
  logic [15:0] rd_word;
  logic [15:0] dev_mem [int];
  logic [15:0] ref_mem [int];
  logic [15:0] last_rd;

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 40503 + 4951);
  endfunction

  function automatic logic [15:0] ref_read(logic [20:0] a);
    int k = int'(a);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
  endfunction

  task automatic ref_write(logic [20:0] a, logic [1:0] s,
                           logic [15:0] d);
    logic [15:0] w = ref_read(a);
    if (s[1]) w[15:8] = d[15:8];
    if (s[0]) w[7:0]  = d[7:0];
    ref_mem[int'(a)] = w;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #2;
  endtask

  // SDRAM controller model: reacts at #1, bench acts at #2
  initial begin
    int          wa;
    logic [15:0] w;
    ctl_ready = 1'b1;
    ctl_dout  = '0;
    busy_left = 0;
    start     = 0;
    prev_p    = 0;
    forever begin
      @(posedge clk_p);
      #1;
      if (reset) begin
        start     = 0;
        busy_left = 0;
        ctl_ready = 1'b1;
        prev_p    = 0;
      end else begin
        if (start) begin
          ctl_ready = 1'b0;
          busy_left = busy_n;
          start     = 0;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            ctl_ready = 1'b1;
            ctl_dout  = rd_word;
          end
        end
        cur_p = ctl_rd || ctl_we;
        if (ctl_rd && ctl_we) proto_err++;
        if (cur_p && prev_p) proto_err++;
        prev_p = cur_p;
        if (cur_p) begin
          n_pulse++;
          last_pulse = cyc;
          cap_addr   = ctl_addr;
          cap_wtbt   = ctl_wtbt;
          cap_din    = ctl_din;
          cap_we     = ctl_we;
          wa = int'(ctl_addr);
          w  = dev_mem.exists(wa) ? dev_mem[wa]
                                  : init_val(wa >> 1);
          if (ctl_we) begin
            if (ctl_wtbt[1]) w[15:8] = ctl_din[15:8];
            if (ctl_wtbt[0]) w[7:0]  = ctl_din[7:0];
            dev_mem[wa] = w;
          end
          rd_word = w;
          if (never_drop) ctl_dout = w;
          else start = 1;
        end
      end
    end
  end

  task automatic do_init();
    reset  = 1'b1;
    wb_stb = 1'b0;
    tick();
    tick();
    chk("rst_init", ctl_init, 1);
    chk("rst_rdy", sdram_ready, 0);
    chk("rst_ack", wb_ack, 0);
    chk("rst_rd", ctl_rd, 0);
    chk("rst_we", ctl_we, 0);
    chk("rst_addr", ctl_addr, 0);
    chk("rst_wtbt", ctl_wtbt, 0);
    chk("rst_din", ctl_din, 0);
    chk("rst_dato", wb_dat_o, 0);
    reset = 1'b0;
    chk("init_rel", ctl_init, 1);
    for (int i = 1; i <= HOLD_TB + 1; i++) begin
      tick();
      chk("init_hold", ctl_init, i < HOLD_TB);
      chk("rdy_flag", sdram_ready, i == HOLD_TB + 1);
      chk("init_noack", wb_ack, 0);
    end
    last_rd = '0;
  endtask

  task automatic xfer(bit we, logic [20:0] adr, logic [1:0] sel,
                      logic [15:0] dat, int busy, bit nodrop,
                      int hold);
    int          s_cyc;
    int          p0;
    int          ack_cyc = 0;
    bit          got = 0;
    logic [15:0] exp_rd;
    busy_n     = busy;
    never_drop = nodrop;
    p0         = n_pulse;
    exp_rd     = ref_read(adr);
    wb_we      = we;
    wb_adr     = adr;
    wb_sel     = sel;
    wb_dat_i   = dat;
    wb_stb     = 1'b1;
    s_cyc      = cyc;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (wb_ack === 1'b1) begin
        got     = 1;
        ack_cyc = cyc;
      end
    end
    chk("ack_seen", wb_ack, 1);
    chk("pulse_cnt", n_pulse - p0, 1);
    chk("req_lat", last_pulse - s_cyc, 2);
    chk("ack_lat", ack_cyc - last_pulse,
        nodrop ? TMO_TB : busy + 2);
    chk("addr", cap_addr, 25'(int'(adr) * 2));
    chk("wtbt", cap_wtbt, we ? sel : 2'b11);
    chk("dir", cap_we, we);
    if (we) begin
      chk("din", cap_din, dat);
      ref_write(adr, sel, dat);
      chk("dat_keep", wb_dat_o, last_rd);
    end else begin
      chk("rdata", wb_dat_o, exp_rd);
      last_rd = exp_rd;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("ack_held", wb_ack, 1);
    end
    chk("one_pulse", n_pulse - p0, 1);
    wb_stb = 1'b0;
    tick();
    chk("ack_fall", wb_ack, 0);
  endtask

  initial begin
    int p0;
    int acks;
    reset    = 1'b1;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_sel   = 2'b00;
    wb_adr   = '0;
    wb_dat_i = '0;
    #1;
    chk("rst_async", ctl_init, 1);

    do_init();

    dev_mem[25'h000246] = 16'hBEEF;
    ref_mem[21'h00123]  = 16'hBEEF;
    xfer(0, 21'h00123, 2'b11, 16'h0, 5, 0, 0);
    chk("beef", wb_dat_o, 16'hBEEF);

    xfer(1, 21'h00040, 2'b10, 16'h1234, 3, 0, 3);
    xfer(0, 21'h00040, 2'b11, 16'h0, 2, 0, 0);

    xfer(0, 21'h1FFFFF, 2'b11, 16'h0, 0, 1, 1);
    xfer(1, 21'h00077, 2'b01, 16'hA55A, 0, 1, 0);

    // stb held in DONE, then reused after one low cycle
    xfer(0, 21'h00123, 2'b11, 16'h0, 1, 0, 5);
    xfer(1, 21'h00123, 2'b11, 16'hC0DE, 1, 0, 0);

    // abort: stb drops while controller busy
    p0         = n_pulse;
    busy_n     = 6;
    never_drop = 0;
    wb_we      = 1'b0;
    wb_adr     = 21'h00005;
    wb_stb     = 1'b1;
    for (int i = 0; i < 10 && n_pulse == p0; i++) tick();
    tick();
    tick();
    wb_stb = 1'b0;
    acks   = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wb_ack) acks++;
    end
    chk("abort_noack", acks, 0);
    chk("abort_dat", wb_dat_o, last_rd);
    chk("abort_pulse", n_pulse - p0, 1);

    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom_range(0, 1)),
           21'($urandom_range(0, 7) * 21'h1001),
           2'($urandom_range(1, 3)),
           16'($urandom),
           $urandom_range(1, 6),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2));
    end

    // reset while controller access is in flight
    p0         = n_pulse;
    busy_n     = 6;
    never_drop = 0;
    wb_we      = 1'b0;
    wb_adr     = 21'h00123;
    wb_stb     = 1'b1;
    for (int i = 0; i < 10 && n_pulse == p0; i++) tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_init", ctl_init, 1);
    chk("mid_ack", wb_ack, 0);
    chk("mid_rdy", sdram_ready, 0);
    chk("mid_dato", wb_dat_o, 0);
    wb_stb = 1'b0;
    do_init();
    xfer(0, 21'h00123, 2'b11, 16'h0, 4, 0, 1);

    chk("protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
